// File: rtl/vga_timing_if.sv
// ----------------------------------------------------------------------------
// vga_timing_if
//   Bundles every signal of the VGA timing generator except clk/reset.
//   The timing generator owns the master modport; the pixel generator and
//   the connector side together form the slave.
//
//   Signal summary (master direction):
//     p_tick      out  1   one-clk pixel-rate enable
//     x, y        out  10  current pixel coordinates
//     video_on    out  1   current (x,y) lies inside the active area
//     frame_start out  1   one-clk pulse when the counters wrap to (0,0)
//     hsync       out  1   horizontal sync to connector, active-low
//     vsync       out  1   vertical sync to connector, active-low
//     rgb_out     out  12  colour to the DAC, zero while blanked
//     rgb_in      in   12  colour from the pixel generator for (x,y)
//
//   Handshake: there is no backpressure. p_tick is a pure enable; the
//   slave presents rgb_in for the current (x,y) and it is sampled only on
//   clk edges where p_tick is high.
// ----------------------------------------------------------------------------
interface vga_timing_if;
    logic        p_tick;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        video_on;
    logic        frame_start;
    logic        hsync;
    logic        vsync;
    logic [11:0] rgb_out;
    logic [11:0] rgb_in;

    modport master (
        output p_tick,
        output x,
        output y,
        output video_on,
        output frame_start,
        output hsync,
        output vsync,
        output rgb_out,
        input  rgb_in
    );

    modport slave (
        input  p_tick,
        input  x,
        input  y,
        input  video_on,
        input  frame_start,
        input  hsync,
        input  vsync,
        input  rgb_out,
        output rgb_in
    );
endinterface

// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
//   Timing master for the 640x480@60 VGA path. Divides the board clock to a
//   pixel-rate enable, runs the horizontal/vertical counters, presents the
//   pixel coordinates and video_on to the pixel generator, and drives the
//   registered hsync/vsync/rgb_out to the connector.
//
//   Ports:
//     clk    in   system clock (100 MHz by default)
//     reset  in   asynchronous, active-high
//     vga    master modport of vga_timing_if (see that file for signals)
//
//   Pipeline:
//     stage 0  divider -> p_tick, x/y counters, video_on (comb from x/y)
//     stage 1  hsync/vsync/rgb_out captured from stage 0 on the same p_tick
//              edge that advances the counters, so the connector signals lag
//              x/y/video_on by exactly one pixel period and stay aligned
//              with each other.
//
//   Parameters must keep H_TOTAL and V_TOTAL within 1024 counts; CLK_DIV
//   must be at least 2.
// ----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic         clk,
    input  logic         reset,
    vga_timing_if.master vga
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam int              DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] X_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_ACTIVE  = 10'(H_DISPLAY);
    localparam logic [9:0] Y_ACTIVE  = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST  = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST  = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DIV_W-1:0] r_div;
    logic             r_p_tick;
    logic [9:0]       r_x;
    logic [9:0]       r_y;
    logic             r_frame_start;
    logic             r_hsync;
    logic             r_vsync;
    logic [11:0]      r_rgb;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic       w_x_last;
    logic       w_y_last;
    logic [9:0] w_x_next;
    logic [9:0] w_y_next;
    logic       w_video_on;
    logic       w_hsync_zone;
    logic       w_vsync_zone;

    always_comb begin
        w_x_last     = (r_x == X_LAST);
        w_y_last     = (r_y == Y_LAST);
        w_x_next     = r_x + 10'd1;
        w_y_next     = r_y;
        if (w_x_last) begin
            w_x_next = 10'd0;
            w_y_next = w_y_last ? 10'd0 : (r_y + 10'd1);
        end
        w_video_on   = (r_x < X_ACTIVE) && (r_y < Y_ACTIVE);
        w_hsync_zone = (r_x >= HS_FIRST) && (r_x <= HS_LAST);
        w_vsync_zone = (r_y >= VS_FIRST) && (r_y <= VS_LAST);
    end

    // ------------------------------------------------------------------------
    // Clock divider: p_tick is registered, so it rises on the edge after the
    // divider reads its last value -- the first pulse follows clk edge
    // CLK_DIV after reset release, then one every CLK_DIV clks.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div    <= '0;
            r_p_tick <= 1'b0;
        end else if (r_div == DIV_LAST) begin
            r_div    <= '0;
            r_p_tick <= 1'b1;
        end else begin
            r_div    <= r_div + 1'b1;
            r_p_tick <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 0: pixel counters. frame_start is raised by the same edge that
    // wraps the counters, so it is high exactly while x/y first read (0,0).
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x           <= 10'd0;
            r_y           <= 10'd0;
            r_frame_start <= 1'b0;
        end else if (r_p_tick) begin
            r_x           <= w_x_next;
            r_y           <= w_y_next;
            r_frame_start <= w_x_last && w_y_last;
        end else begin
            r_frame_start <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 1: connector outputs. They capture the stage-0 values present
    // before the counters move, which gives the one-pixel lag. rgb_in is
    // looked at only on p_tick edges, so mid-pixel changes never leak out.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_rgb   <= 12'h000;
        end else if (r_p_tick) begin
            r_hsync <= ~w_hsync_zone;
            r_vsync <= ~w_vsync_zone;
            r_rgb   <= w_video_on ? vga.rgb_in : 12'h000;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign vga.p_tick      = r_p_tick;
    assign vga.x           = r_x;
    assign vga.y           = r_y;
    assign vga.video_on    = w_video_on;
    assign vga.frame_start = r_frame_start;
    assign vga.hsync       = r_hsync;
    assign vga.vsync       = r_vsync;
    assign vga.rgb_out     = r_rgb;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Two instances share clk/reset/rgb_in: one with the default 640x480
//   timing (run for two lines) and one with a shrunken raster so whole
//   frames, vsync and a mid-sync reset fit in a short run. Expected values
//   come from a pixel-index model: the number of clk edges since reset
//   release gives the pixel index, and x/y/sync/blanking follow from it by
//   division and range tests.
// ----------------------------------------------------------------------------
module tb_vga_timing_gen;

    typedef struct {
        int hd; int hf; int hsw; int hb;
        int vd; int vf; int vsw; int vb;
    } timing_t;

    typedef struct {
        int x; int y; bit von; bit hs; bit vs;
    } pix_t;

    localparam timing_t FULL_T  = '{640, 16, 96, 48, 480, 10, 2, 33};
    localparam timing_t SMALL_T = '{16, 4, 6, 4, 10, 2, 2, 3};
    localparam int      DIV     = 4;

    // ------------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------------
    logic        clk    = 1'b0;
    logic        reset  = 1'b0;
    logic [11:0] rgb_in = 12'hABC;

    always #5 clk = ~clk;

    vga_timing_if bus_full ();
    vga_timing_if bus_small ();

    assign bus_full.rgb_in  = rgb_in;
    assign bus_small.rgb_in = rgb_in;

    vga_timing_gen #(
        .CLK_DIV(DIV),
        .H_DISPLAY(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
        .V_DISPLAY(480), .V_FRONT(10), .V_SYNC(2),  .V_BACK(33)
    ) u_dut_full (
        .clk(clk),
        .reset(reset),
        .vga(bus_full)
    );

    vga_timing_gen #(
        .CLK_DIV(DIV),
        .H_DISPLAY(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
        .V_DISPLAY(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) u_dut_small (
        .clk(clk),
        .reset(reset),
        .vga(bus_small)
    );

    // ------------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------------
    int          n_checks = 0;
    int          n_errors = 0;
    int          k        = 0;        // clk edges since reset release
    logic [11:0] last_rgb = 12'h000;  // rgb_in on the most recent pixel edge
    bit          rand_rgb = 1'b0;

    int full_hs_low  = 0;
    int small_vs_low = 0;
    int full_fs      = 0;
    int small_fs     = 0;
    int blank_viol   = 0;

    // Pixel edges are clk edges 5, 9, 13, ... after release (the edge after
    // each p_tick rise at 4, 8, 12, ...).
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            k        <= 0;
            last_rgb <= 12'h000;
        end else begin
            k <= k + 1;
            if (k >= DIV && (k % DIV) == 0) last_rgb <= rgb_in;
        end
    end

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    function automatic int h_total(input timing_t t);
        return t.hd + t.hf + t.hsw + t.hb;
    endfunction

    function automatic int v_total(input timing_t t);
        return t.vd + t.vf + t.vsw + t.vb;
    endfunction

    function automatic int pixel_index(input int edges);
        return (edges == 0) ? 0 : (edges - 1) / DIV;
    endfunction

    function automatic pix_t pix_at(input timing_t t, input int p);
        pix_t r;
        r.x   = p % h_total(t);
        r.y   = (p / h_total(t)) % v_total(t);
        r.von = (r.x < t.hd) && (r.y < t.vd);
        r.hs  = !((r.x >= t.hd + t.hf) && (r.x < t.hd + t.hf + t.hsw));
        r.vs  = !((r.y >= t.vd + t.vf) && (r.y < t.vd + t.vf + t.vsw));
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_bus(input string tag, input timing_t t,
                             input logic p_tick, input logic [9:0] x, input logic [9:0] y,
                             input logic von, input logic fs, input logic hs, input logic vs,
                             input logic [11:0] rgb);
        int          p;
        pix_t        cur;
        pix_t        prev;
        bit          e_tick;
        bit          e_fs;
        bit          e_hs;
        bit          e_vs;
        logic [11:0] e_rgb;
        p      = pixel_index(k);
        cur    = pix_at(t, p);
        e_tick = (k >= DIV) && ((k % DIV) == 0);
        e_fs   = (k > DIV) && (((k - 1) % DIV) == 0) && ((p % (h_total(t) * v_total(t))) == 0);
        e_hs   = 1'b1;
        e_vs   = 1'b1;
        e_rgb  = 12'h000;
        if (p > 0) begin
            prev  = pix_at(t, p - 1);
            e_hs  = prev.hs;
            e_vs  = prev.vs;
            e_rgb = prev.von ? last_rgb : 12'h000;
        end
        check_eq({tag, ".p_tick"},      32'(p_tick), 32'(e_tick));
        check_eq({tag, ".x"},           32'(x),      32'(cur.x));
        check_eq({tag, ".y"},           32'(y),      32'(cur.y));
        check_eq({tag, ".video_on"},    32'(von),    32'(cur.von));
        check_eq({tag, ".frame_start"}, 32'(fs),     32'(e_fs));
        check_eq({tag, ".hsync"},       32'(hs),     32'(e_hs));
        check_eq({tag, ".vsync"},       32'(vs),     32'(e_vs));
        check_eq({tag, ".rgb_out"},     32'(rgb),    32'(e_rgb));
    endtask

    // ------------------------------------------------------------------------
    // Driver: one clk per call, checks on the falling edge, then drives.
    // ------------------------------------------------------------------------
    task automatic step();
        int p;
        @(negedge clk);
        check_bus("full", FULL_T, bus_full.p_tick, bus_full.x, bus_full.y, bus_full.video_on,
                  bus_full.frame_start, bus_full.hsync, bus_full.vsync, bus_full.rgb_out);
        check_bus("small", SMALL_T, bus_small.p_tick, bus_small.x, bus_small.y, bus_small.video_on,
                  bus_small.frame_start, bus_small.hsync, bus_small.vsync, bus_small.rgb_out);
        p = pixel_index(k);
        if (bus_full.p_tick && !bus_full.hsync && p < h_total(FULL_T)) full_hs_low++;
        if (bus_small.p_tick && !bus_small.vsync && p < h_total(SMALL_T) * v_total(SMALL_T))
            small_vs_low++;
        if (bus_full.frame_start)  full_fs++;
        if (bus_small.frame_start) small_fs++;
        if ((!bus_full.hsync || !bus_full.vsync) && bus_full.rgb_out != 12'h000) blank_viol++;
        if ((!bus_small.hsync || !bus_small.vsync) && bus_small.rgb_out != 12'h000) blank_viol++;
        if (rand_rgb) rgb_in = 12'($urandom_range(0, 4095));
    endtask

    task automatic count_ticks(input int n, output int cnt, output int first);
        cnt   = 0;
        first = 0;
        for (int i = 1; i <= n; i++) begin
            step();
            if (bus_full.p_tick) begin
                cnt++;
                if (first == 0) first = i;
            end
        end
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int   cnt;
        int   first;
        bit   found;
        pix_t pix;

        #2 reset = 1'b1;
        repeat (3) step();
        check_eq("rst.video_on", 32'(bus_full.video_on), 32'd1);
        check_eq("rst.hsync",    32'(bus_full.hsync),    32'd1);

        // Release, then the first 40 clks: pulses at 4, 8, ..., 40.
        reset = 1'b0;
        count_ticks(40, cnt, first);
        check_eq("first40.tick_count", 32'(cnt),   32'd10);
        check_eq("first40.first_tick", 32'(first), 32'd4);
        step();
        check_eq("first40.x_reached", 32'(bus_full.x), 32'd10);
        check_eq("first40.y",         32'(bus_full.y), 32'd0);

        // Constant colour for a while, then a new random colour every clk.
        repeat (60) step();
        rand_rgb = 1'b1;
        repeat (6400) step();

        check_eq("line0.hsync_low_ticks",  32'(full_hs_low),  32'(FULL_T.hsw));
        check_eq("frame0.vsync_low_ticks", 32'(small_vs_low), 32'(SMALL_T.vsw * h_total(SMALL_T)));
        check_eq("full.frame_starts",      32'(full_fs),      32'd0);
        check_eq("small.frame_starts",     32'(small_fs),
                 32'(pixel_index(k) / (h_total(SMALL_T) * v_total(SMALL_T))));
        check_eq("sync_blanking",          32'(blank_viol),   32'd0);

        // Walk the small raster into the middle of both sync pulses.
        found = 1'b0;
        for (int i = 0; i < 4000 && !found; i++) begin
            step();
            pix = pix_at(SMALL_T, pixel_index(k));
            if (pix.x == 23 && pix.y == 12) found = 1'b1;
        end
        check_eq("midsync.reached", 32'(found), 32'd1);
        check_eq("midsync.pre_hsync", 32'(bus_small.hsync), 32'd0);
        check_eq("midsync.pre_vsync", 32'(bus_small.vsync), 32'd0);

        // Asynchronous reset between clk edges.
        #1 reset = 1'b1;
        #1;
        check_eq("arst.x",           32'(bus_small.x),           32'd0);
        check_eq("arst.y",           32'(bus_small.y),           32'd0);
        check_eq("arst.hsync",       32'(bus_small.hsync),       32'd1);
        check_eq("arst.vsync",       32'(bus_small.vsync),       32'd1);
        check_eq("arst.rgb_out",     32'(bus_small.rgb_out),     32'd0);
        check_eq("arst.p_tick",      32'(bus_small.p_tick),      32'd0);
        check_eq("arst.frame_start", 32'(bus_small.frame_start), 32'd0);
        check_eq("arst.video_on",    32'(bus_small.video_on),    32'd1);
        check_eq("arst.full_x",      32'(bus_full.x),            32'd0);

        repeat (2) step();
        reset = 1'b0;
        count_ticks(40, cnt, first);
        check_eq("rerun.tick_count", 32'(cnt),   32'd10);
        check_eq("rerun.first_tick", 32'(first), 32'd4);
        repeat (800) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
